// File: rtl/present_ctr.sv
// CTR-mode front end for an iterative PRESENT-80 core: keeps one keystream
// block ready ahead and XORs it into a single-entry valid/ready data stream.
module present_ctr (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [80-1:0]     cfg_key,
  input  logic [64-1:0]     cfg_iv,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [64-1:0]     in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [64-1:0]     out_data,
  output logic              core_start,
  output logic [80-1:0]     core_key,
  output logic [64-1:0]     core_block,
  input  logic [64-1:0]     core_ct,
  input  logic              core_done
);

  localparam int unsigned BLK_W   = 64;
  localparam int unsigned GCNT_W  = 2;
  localparam logic [GCNT_W-1:0] DONE_ARM = GCNT_W'(2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GEN   = 2'd1,
    READY = 2'd2
  } state_t;

  state_t              state;
  logic [BLK_W-1:0]    ctr;
  logic [BLK_W-1:0]    ks_reg;
  logic [GCNT_W-1:0]   gen_cnt;
  logic                cfg_fire;
  logic                in_fire;

  // Handshake qualifiers: decoded from registered state plus the downstream ready.
  assign cfg_ready = (state != GEN);
  assign in_ready  = (state == READY) && (!out_valid || out_ready);
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign in_fire   = in_valid && in_ready;

  // core_key doubles as the held key; it only moves when a new config is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_data   <= '0;
      core_start <= 1'b0;
      core_key   <= '0;
      core_block <= '0;
      ctr        <= '0;
      ks_reg     <= '0;
      gen_cnt    <= '0;
    end else begin
      core_start <= 1'b0;

      if (in_fire) begin
        out_data  <= in_data ^ ks_reg;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE, READY: begin
          // A simultaneous data word still uses the old ks_reg (above); config wins the core.
          if (cfg_fire) begin
            core_key   <= cfg_key;
            core_block <= cfg_iv;
            ctr        <= cfg_iv;
            core_start <= 1'b1;
            gen_cnt    <= '0;
            state      <= GEN;
          end else if (in_fire) begin
            core_block <= ctr;
            core_start <= 1'b1;
            gen_cnt    <= '0;
            state      <= GEN;
          end
        end
        GEN: begin
          // core_done may be stale from the previous run for the first two cycles.
          if (gen_cnt != DONE_ARM) begin
            gen_cnt <= gen_cnt + GCNT_W'(1);
          end else if (core_done) begin
            ks_reg <= core_ct;
            ctr    <= ctr + BLK_W'(1);
            state  <= READY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
